// File: rtl/poly_note_player.sv
// poly_note_player: VOICES independent note slots, each with its own beat
// counter and phase accumulator. The slots are mixed into one signed 16-bit
// sample per request by a sequencer that runs FREQ/STEP/SINE once per slot.
// The frequency and quarter-wave sine tables are built in as registered
// lookups: step = note * 5461, sine(a) = a * (2047 - a) / 32.
module poly_note_player #(
  parameter int VOICES = 2,
  parameter int VSEL_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [VSEL_W-1:0] load_voice,
  input  logic [5:0]        note_to_load,
  input  logic [5:0]        duration_to_load,
  input  logic              beat,
  input  logic              generate_next_sample,
  output logic [VOICES-1:0] voice_busy,
  output logic [VOICES-1:0] done_with_note,
  output logic [15:0]       sample_out,
  output logic              new_sample_ready
);

  localparam int DATA_W = 16;
  localparam int SHIFT  = (VOICES == 4) ? 2 : ((VOICES == 2) ? 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_FREQ, S_STEP, S_SINE, S_OUT} state_t;

  state_t                    r_state, w_next;
  logic [VSEL_W-1:0]         r_v;
  logic [5:0]                r_note   [VOICES];
  logic [5:0]                r_rem    [VOICES];
  logic [21:0]               r_phase  [VOICES];
  logic [VOICES-1:0]         r_active;
  logic [VOICES-1:0]         r_done;
  logic [19:0]               r_step_p1;
  logic signed [DATA_W-1:0]  r_sine_p2;
  logic [1:0]                r_quad_p2;
  logic signed [17:0]        r_acc;
  logic signed [DATA_W-1:0]  r_sample;

  logic                      w_last;
  logic                      w_cur_play;
  logic                      w_beat_en;
  logic                      w_accept;
  logic                      w_step_wr;
  logic [21:0]               w_phase_new;
  logic [9:0]                w_addr;
  logic signed [DATA_W-1:0]  w_sine_val;
  logic signed [17:0]        w_contrib;
  logic signed [17:0]        w_acc_sum;

  function automatic logic [19:0] freq_lut(input logic [5:0] n);
    return 20'(int'(n) * 5461);
  endfunction

  function automatic logic signed [DATA_W-1:0] sine_lut(input logic [9:0] a);
    int x;
    x = int'(a);
    return DATA_W'((x * (2047 - x)) >>> 5);
  endfunction

  // Dividing by the voice count with an arithmetic shift keeps the mix in range.
  function automatic logic signed [DATA_W-1:0] mix_scale(input logic signed [17:0] acc);
    return DATA_W'(acc >>> SHIFT);
  endfunction

  assign w_last      = (r_v == VSEL_W'(VOICES - 1));
  assign w_cur_play  = r_active[r_v] && (r_note[r_v] != 6'd0);
  assign w_beat_en   = beat && play_enable;
  assign w_accept    = generate_next_sample && play_enable;
  assign w_step_wr   = (r_state == S_STEP) && w_cur_play;
  assign w_phase_new = w_cur_play ? (r_phase[r_v] + {2'b00, r_step_p1}) : r_phase[r_v];
  assign w_addr      = w_phase_new[20] ? ~w_phase_new[19:10] : w_phase_new[19:10];
  assign w_sine_val  = r_quad_p2[1] ? -r_sine_p2 : r_sine_p2;
  assign w_contrib   = w_cur_play ? {{2{w_sine_val[DATA_W-1]}}, w_sine_val} : 18'sd0;
  assign w_acc_sum   = r_acc + w_contrib;

  assign voice_busy       = r_active;
  assign done_with_note   = r_done;
  assign sample_out       = r_sample;
  assign new_sample_ready = (r_state == S_OUT);

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Sequencer next-state: one FREQ/STEP/SINE triple per slot, then OUT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_FREQ;
      S_FREQ:  w_next = S_STEP;
      S_STEP:  w_next = S_SINE;
      S_SINE:  w_next = w_last ? S_OUT : S_FREQ;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sequencer datapath: step lookup, phase-to-sine lookup, mix accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v       <= '0;
      r_step_p1 <= '0;
      r_sine_p2 <= '0;
      r_quad_p2 <= '0;
      r_acc     <= '0;
      r_sample  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc <= '0;
            r_v   <= '0;
          end
        end
        // stage p1: note -> phase step
        S_FREQ: r_step_p1 <= freq_lut(r_note[r_v]);
        // stage p2: advanced phase -> quarter-wave sample plus its quadrant
        S_STEP: begin
          r_sine_p2 <= sine_lut(w_addr);
          r_quad_p2 <= w_phase_new[21:20];
        end
        // stage p3: signed sample into the mix; last slot publishes the result
        S_SINE: begin
          r_acc <= w_acc_sum;
          if (w_last) r_sample <= mix_scale(w_acc_sum);
          else        r_v      <= r_v + VSEL_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Slot state: loads win over beats and phase steps for their own slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++) begin
        r_note[v]  <= '0;
        r_rem[v]   <= '0;
        r_phase[v] <= '0;
      end
      r_active <= '0;
      r_done   <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        r_done[v] <= 1'b0;
        if (load_new_note && (load_voice == VSEL_W'(v))) begin
          r_note[v]   <= note_to_load;
          r_rem[v]    <= duration_to_load;
          r_phase[v]  <= '0;
          r_active[v] <= (duration_to_load != 6'd0);
          r_done[v]   <= (duration_to_load == 6'd0);
        end else begin
          if (w_beat_en && r_active[v]) begin
            r_rem[v] <= r_rem[v] - 6'd1;
            if (r_rem[v] == 6'd1) begin
              r_active[v] <= 1'b0;
              r_done[v]   <= 1'b1;
            end
          end
          if (w_step_wr && (r_v == VSEL_W'(v))) r_phase[v] <= w_phase_new;
        end
      end
    end
  end

endmodule
